i2c_write_sequencer: RTL

- Transaction-level controller for the I2C byte-write engine; emits the byte-level command/go stream for one complete master write: START, address+W, N data bytes, STOP.
- Checks the slave ACK after every byte through a separate 1-bit read-ACK engine, and aborts to STOP on NACK.
- Sits between the host/register interface and the byte-write engine; owns sequencing and MSB-first bit feeding only, never drives SCL/SDA.

---
 rtl/i2c_pkg.sv | 38 +++
 rtl/i2c_tx_shifter.sv | 36 +++
 rtl/i2c_write_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte-engine and bit-engine command codes, sequencer states.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_IDLE  = 3'b000,
    CMD_START = 3'b001,
    CMD_ACK   = 3'b010,
    CMD_DATA  = 3'b011,
    CMD_STOP  = 3'b100,
    CMD_NACK  = 3'b101
  } byte_cmd_e;

  typedef enum logic [2:0] {
    BIT_IDLE  = 3'b000,
    BIT_START = 3'b001,
    BIT_WRITE = 3'b010,
    BIT_READ  = 3'b011,
    BIT_STOP  = 3'b100
  } bit_cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_GAP      = 4'd2,
    ST_ADDR     = 4'd3,
    ST_ADDR_ACK = 4'd4,
    ST_FETCH    = 4'd5,
    ST_LOAD     = 4'd6,
    ST_DATA     = 4'd7,
    ST_DATA_ACK = 4'd8,
    ST_STOP     = 4'd9,
    ST_DONE     = 4'd10
  } seq_state_e;

endpackage

// File: rtl/i2c_tx_shifter.sv
// 8-bit transmit shift register: parallel load, shift left on request, MSB out.
module i2c_tx_shifter
  import i2c_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] load_data_i,
  input  logic              shift_i,
  output logic              msb_o
);

  logic [BYTE_W-1:0] shreg_q;
  logic [BYTE_W-1:0] shreg_d;

  // Load wins over shift so a new byte is never corrupted by a stray strobe.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = load_data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[BYTE_W-1];

endmodule

// File: rtl/i2c_write_sequencer.sv
// Transaction sequencer for one I2C master write: START, addr+W, N data bytes, STOP.
module i2c_write_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic [7:0]        wr_data,
  output logic              wr_data_req,
  output logic              busy,
  output logic              done,
  output logic              nack_err,
  output logic [2:0]        wb_command,
  output logic              wb_go,
  output logic              wb_data,
  input  logic              wb_finish,
  input  logic              wb_load,
  output logic              ra_go,
  input  logic              ra_finish,
  input  logic              ra_ack
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              nack_err_q, nack_err_d;

  byte_cmd_e         wb_command_q, wb_command_d;
  logic              wb_go_q, wb_go_d;
  logic              ra_go_q, ra_go_d;
  logic              wr_data_req_q, wr_data_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sh_load;
  logic              sh_shift;
  logic [BYTE_W-1:0] sh_load_data;

  // State, captured transaction fields and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      nack_err_q    <= 1'b0;
      wb_command_q  <= CMD_IDLE;
      wb_go_q       <= 1'b0;
      ra_go_q       <= 1'b0;
      wr_data_req_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      nack_err_q    <= nack_err_d;
      wb_command_q  <= wb_command_d;
      wb_go_q       <= wb_go_d;
      ra_go_q       <= ra_go_d;
      wr_data_req_q <= wr_data_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state and transaction bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    nack_err_d  = nack_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = dev_addr;
          remaining_d = byte_count;
          nack_err_d  = 1'b0;
          state_d     = ST_START;
        end
      end
      ST_START:    if (wb_finish) state_d = ST_GAP;
      ST_GAP:      state_d = ST_ADDR;
      ST_ADDR:     if (wb_finish) state_d = ST_ADDR_ACK;
      ST_ADDR_ACK, ST_DATA_ACK: begin
        if (ra_finish) begin
          if (ra_ack) begin
            nack_err_d = 1'b1;
            state_d    = ST_STOP;
          end else if (remaining_q == '0) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH:    state_d = ST_LOAD;
      ST_LOAD: begin
        remaining_d = remaining_q - CNT_W'(1);
        state_d     = ST_DATA;
      end
      ST_DATA:     if (wb_finish) state_d = ST_DATA_ACK;
      ST_STOP:     if (wb_finish) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    wb_command_d  = CMD_IDLE;
    wb_go_d       = 1'b0;
    ra_go_d       = 1'b0;
    wr_data_req_d = 1'b0;
    busy_d        = 1'b1;
    done_d        = 1'b0;
    case (state_d)
      ST_IDLE:  busy_d = 1'b0;
      ST_START: begin
        wb_command_d = CMD_START;
        wb_go_d      = 1'b1;
      end
      ST_ADDR, ST_DATA: begin
        wb_command_d = CMD_DATA;
        wb_go_d      = 1'b1;
      end
      ST_ADDR_ACK, ST_DATA_ACK: ra_go_d = 1'b1;
      ST_FETCH: wr_data_req_d = 1'b1;
      ST_STOP: begin
        wb_command_d = CMD_STOP;
        wb_go_d      = 1'b1;
      end
      ST_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign sh_load      = (state_q == ST_GAP) || (state_q == ST_LOAD);
  assign sh_load_data = (state_q == ST_LOAD) ? wr_data : BYTE_W'({addr_q, 1'b0});
  assign sh_shift     = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !wb_load;

  i2c_tx_shifter u_shifter (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_i      (sh_load),
    .load_data_i (sh_load_data),
    .shift_i     (sh_shift),
    .msb_o       (wb_data)
  );

  assign wb_command  = wb_command_q;
  assign wb_go       = wb_go_q;
  assign ra_go       = ra_go_q;
  assign wr_data_req = wr_data_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign nack_err    = nack_err_q;

endmodule
